// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants and derived sync window bounds
// shared by the VGA timing generator and its helpers.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
  localparam int DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

  localparam int CNT_W = 10;

  // Timing-mode record, kept for when more video modes are added
  typedef struct packed {
    logic [CNT_W-1:0] h_active;
    logic [CNT_W-1:0] h_fp;
    logic [CNT_W-1:0] h_sync;
    logic [CNT_W-1:0] h_bp;
    logic [CNT_W-1:0] v_active;
    logic [CNT_W-1:0] v_fp;
    logic [CNT_W-1:0] v_sync;
    logic [CNT_W-1:0] v_bp;
    logic             sync_active_low;
  } timing_mode_t;

  function automatic int mode_h_total(input timing_mode_t m);
    return int'(m.h_active) + int'(m.h_fp) + int'(m.h_sync) + int'(m.h_bp);
  endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Enable-qualified shift register with synchronous clear; depth 0 is a
// plain wire so callers can tune alignment down to zero latency.
module sync_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign q = d;
    end else begin : g_pipe
      logic [DEPTH-1:0][WIDTH-1:0] stg;

      always_ff @(posedge clk) begin
        if (rst) begin
          stg <= '0;
        end else if (en) begin
          stg[0] <= d;
          for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
        end
      end

      assign q = stg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters plus delayed active-video / sync outputs, advanced by
// a pixel-enable strobe so the same block runs from 25 MHz or 100 MHz.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE        = DEF_H_ACTIVE,
  parameter int H_FP            = DEF_H_FP,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BP            = DEF_H_BP,
  parameter int V_ACTIVE        = DEF_V_ACTIVE,
  parameter int V_FP            = DEF_V_FP,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BP            = DEF_V_BP,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int SYNC_DELAY      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_ce,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic             display_on,
  output logic             Hsync,
  output logic             Vsync,
  output logic             line_start,
  output logic             frame_start,
  output logic [7:0]       frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic       h_wrap, v_wrap;
  logic [2:0] raw, dly;

  assign h_wrap = (h_count == H_LAST);
  assign v_wrap = (v_count == V_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      h_count     <= '0;
      v_count     <= '0;
      frame_count <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_ce) begin
        if (h_wrap) begin
          h_count    <= '0;
          line_start <= 1'b1;
          if (v_wrap) begin
            v_count     <= '0;
            frame_start <= 1'b1;
            frame_count <= frame_count + 8'd1;
          end else begin
            v_count <= v_count + 1'b1;
          end
        end else begin
          h_count <= h_count + 1'b1;
        end
      end
    end
  end

  // Raw flags are active-high; pin polarity is applied after the delay
  // so cleared delay stages already read as the inactive sync level.
  always_comb begin
    raw    = '0;
    raw[2] = (h_count < H_ACT) && (v_count < V_ACT);
    raw[1] = (h_count >= HS_START) && (h_count < HS_END);
    raw[0] = (v_count >= VS_START) && (v_count < VS_END);
  end

  sync_delay_line #(
    .WIDTH (3),
    .DEPTH (SYNC_DELAY)
  ) u_dly (
    .clk (clk),
    .rst (rst),
    .en  (pix_ce),
    .d   (raw),
    .q   (dly)
  );

  assign display_on = dly[2];
  assign Hsync      = dly[1] ^ SYNC_ACTIVE_LOW;
  assign Vsync      = dly[0] ^ SYNC_ACTIVE_LOW;

endmodule
